// File: rtl/debug_reg_dumper_pkg.sv
// Shared definitions for the debug register dumper: default sizes, FSM
// state encoding and a small width helper.
package debug_reg_dumper_pkg;

    localparam int DBG_DATA_SIZE      = 32;
    localparam int DBG_REG_SIZE       = 5;
    localparam int DBG_BANK_SIZE      = 32;
    localparam int DBG_BYTE_SIZE      = 8;
    localparam int DBG_BYTES_PER_WORD = DBG_DATA_SIZE / DBG_BYTE_SIZE;

    localparam logic [2:0] STATE_IDLE = 3'd0;
    localparam logic [2:0] STATE_REQ  = 3'd1;
    localparam logic [2:0] STATE_LOAD = 3'd2;
    localparam logic [2:0] STATE_SEND = 3'd3;
    localparam logic [2:0] STATE_DONE = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = STATE_IDLE,
        ST_REQ  = STATE_REQ,
        ST_LOAD = STATE_LOAD,
        ST_SEND = STATE_SEND,
        ST_DONE = STATE_DONE
    } dump_state_t;

    // Counter width able to index n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/debug_reg_dumper_if.sv
// Bus between the dumper and its environment: register bank debug read
// port, UART TX byte handshake and start/status lines.
interface debug_reg_dumper_if #(
    parameter int DATA_SIZE = 32,
    parameter int REG_SIZE  = 5,
    parameter int BYTE_SIZE = 8
) ();

    logic                 i_start;
    logic                 o_read_enable;
    logic [REG_SIZE-1:0]  o_read_addr;
    logic [DATA_SIZE-1:0] i_read_data;
    logic [BYTE_SIZE-1:0] o_tx_data;
    logic                 o_tx_valid;
    logic                 i_tx_ready;
    logic                 o_busy;
    logic                 o_done;

    // Dumper side.
    modport master (
        input  i_start,
        input  i_read_data,
        input  i_tx_ready,
        output o_read_enable,
        output o_read_addr,
        output o_tx_data,
        output o_tx_valid,
        output o_busy,
        output o_done
    );

    // Environment side: bank model, UART TX and controller.
    modport slave (
        output i_start,
        output i_read_data,
        output i_tx_ready,
        input  o_read_enable,
        input  o_read_addr,
        input  o_tx_data,
        input  o_tx_valid,
        input  o_busy,
        input  o_done
    );

endinterface

// File: rtl/debug_reg_dumper_word_byte_serializer.sv
// Holds one bank word and presents it a byte at a time, LSB byte first.
// The low byte of the shift register is the byte currently on offer.
module word_byte_serializer
    import debug_reg_dumper_pkg::*;
#(
    parameter int DATA_SIZE = DBG_DATA_SIZE,
    parameter int BYTE_SIZE = DBG_BYTE_SIZE
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 load,
    input  logic                 shift,
    input  logic [DATA_SIZE-1:0] word,
    output logic [BYTE_SIZE-1:0] tx_byte,
    output logic                 last_byte
);

    localparam int BPW    = DATA_SIZE / BYTE_SIZE;
    localparam int BIDX_W = idx_width(BPW);
    localparam logic [BIDX_W-1:0] LAST_BIDX = BIDX_W'(BPW - 1);

    logic [DATA_SIZE-1:0] shift_r;
    logic [BIDX_W-1:0]    bidx_r;

    // Load a fresh word, or drop the accepted byte and advance the byte index.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            shift_r <= {DATA_SIZE{1'b0}};
            bidx_r  <= {BIDX_W{1'b0}};
        end else if (load) begin
            shift_r <= word;
            bidx_r  <= {BIDX_W{1'b0}};
        end else if (shift) begin
            shift_r <= shift_r >> BYTE_SIZE;
            if (bidx_r == LAST_BIDX) begin
                bidx_r <= {BIDX_W{1'b0}};
            end else begin
                bidx_r <= bidx_r + {{(BIDX_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign tx_byte   = shift_r[BYTE_SIZE-1:0];
    assign last_byte = (bidx_r == LAST_BIDX);

endmodule

// File: rtl/debug_reg_dumper.sv
// Debug unit sequencer: reads every register of the halted bank through its
// debug port and streams the words, little-endian, to the UART transmitter.
module debug_reg_dumper
    import debug_reg_dumper_pkg::*;
#(
    parameter int DATA_SIZE = DBG_DATA_SIZE,
    parameter int REG_SIZE  = DBG_REG_SIZE,
    parameter int BANK_SIZE = DBG_BANK_SIZE,
    parameter int BYTE_SIZE = DBG_BYTE_SIZE
) (
    input logic                i_clock,
    input logic                i_reset,
    debug_reg_dumper_if.master bus
);

    // One spare bit so BANK_SIZE == 2**REG_SIZE cannot wrap the index.
    localparam int IDX_W = REG_SIZE + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BANK_SIZE - 1);

    dump_state_t          state_r;
    dump_state_t          next_state_s;
    logic [IDX_W-1:0]     idx_r;
    logic                 load_s;
    logic                 shift_s;
    logic                 idx_inc_s;
    logic                 idx_clr_s;
    logic                 last_byte_s;
    logic [BYTE_SIZE-1:0] tx_byte_s;
    logic                 read_enable_r;
    logic                 tx_valid_r;
    logic                 busy_r;
    logic                 done_r;

    // FSM state register.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode and per-state control strobes.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        shift_s      = 1'b0;
        idx_inc_s    = 1'b0;
        idx_clr_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.i_start) begin
                    next_state_s = ST_REQ;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                next_state_s = ST_LOAD;
            end
            ST_LOAD: begin
                load_s       = 1'b1;
                next_state_s = ST_SEND;
            end
            ST_SEND: begin
                if (bus.i_tx_ready) begin
                    shift_s = 1'b1;
                    if (last_byte_s) begin
                        if (idx_r == LAST_IDX) begin
                            next_state_s = ST_DONE;
                        end else begin
                            idx_inc_s    = 1'b1;
                            next_state_s = ST_REQ;
                        end
                    end else begin
                        next_state_s = ST_SEND;
                    end
                end else begin
                    next_state_s = ST_SEND;
                end
            end
            ST_DONE: begin
                idx_clr_s    = 1'b1;
                next_state_s = ST_IDLE;
            end
            default: begin
                idx_clr_s    = 1'b1;
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Word index: advances after each word's last byte, clears on completion.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            idx_r <= {IDX_W{1'b0}};
        end else if (idx_clr_s) begin
            idx_r <= {IDX_W{1'b0}};
        end else if (idx_inc_s) begin
            idx_r <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
        end else begin
            idx_r <= idx_r;
        end
    end

    // Status outputs registered from the next state so they track state_r
    // exactly while never seeing i_tx_ready combinationally.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            read_enable_r <= 1'b0;
            tx_valid_r    <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            read_enable_r <= (next_state_s == ST_REQ);
            tx_valid_r    <= (next_state_s == ST_SEND);
            busy_r        <= (next_state_s != ST_IDLE);
            done_r        <= (next_state_s == ST_DONE);
        end
    end

    word_byte_serializer #(
        .DATA_SIZE (DATA_SIZE),
        .BYTE_SIZE (BYTE_SIZE)
    ) u_serializer (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .load      (load_s),
        .shift     (shift_s),
        .word      (bus.i_read_data),
        .tx_byte   (tx_byte_s),
        .last_byte (last_byte_s)
    );

    assign bus.o_read_enable = read_enable_r;
    assign bus.o_read_addr   = idx_r[REG_SIZE-1:0];
    assign bus.o_tx_data     = tx_byte_s;
    assign bus.o_tx_valid    = tx_valid_r;
    assign bus.o_busy        = busy_r;
    assign bus.o_done        = done_r;

endmodule

// File: tb/tb_debug_reg_dumper.sv
// Scoreboard bench for debug_reg_dumper: a bank model answers debug reads,
// expected bytes are queued per dump and a negedge monitor checks them.
module tb_debug_reg_dumper;

    logic clk;
    logic rst_n;

    debug_reg_dumper_if #(.DATA_SIZE(32), .REG_SIZE(5), .BYTE_SIZE(8)) bus ();

    debug_reg_dumper #(
        .DATA_SIZE (32),
        .REG_SIZE  (5),
        .BANK_SIZE (32),
        .BYTE_SIZE (8)
    ) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    logic [31:0] bank [32];
    logic [7:0]  exp_q [$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          bytes_seen  = 0;
    int          re_cnt      = 0;
    int          re_exp      = 0;
    int          done_cnt    = 0;
    logic        prev_stall  = 1'b0;
    logic [7:0]  prev_data   = 8'h00;

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bank model: registered debug read, one cycle latency.
    always @(posedge clk) begin
        if (bus.o_read_enable) begin
            bus.i_read_data <= bank[bus.o_read_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the full little-endian byte stream of one dump.
    task automatic push_dump();
        logic [31:0] w;
        for (int r = 0; r < 32; r++) begin
            w = bank[r];
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back(w[8*b +: 8]);
            end
        end
    endtask

    // Monitor: checks bytes on handshake, stall stability and read sequence.
    always @(negedge clk) begin
        if (bus.o_tx_valid && bus.i_tx_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL tx_byte: got %02h, expected no byte", bus.o_tx_data);
            end else begin
                check("tx_byte", 32'(bus.o_tx_data), 32'(exp_q.pop_front()));
            end
            bytes_seen++;
        end
        if (bus.o_tx_valid && prev_stall) begin
            check("stall_hold", 32'(bus.o_tx_data), 32'(prev_data));
        end
        prev_stall = bus.o_tx_valid && !bus.i_tx_ready;
        prev_data  = bus.o_tx_data;
        if (bus.o_read_enable) begin
            check("read_addr", 32'(bus.o_read_addr), 32'(re_exp));
            re_exp++;
            re_cnt++;
        end
        if (bus.o_done) begin
            done_cnt++;
        end
    end

    // One dump. Cycle k counts edges after the start pulse was driven.
    task automatic run_dump(input bit rand_rdy, input int restart_at, input int stall_at,
                            input int reset_at, input int exp_done);
        int first_v;
        int done_k;
        first_v    = 0;
        done_k     = 0;
        bytes_seen = 0;
        re_cnt     = 0;
        re_exp     = 0;
        done_cnt   = 0;
        push_dump();
        bus.i_tx_ready = 1'b1;
        bus.i_start    = 1'b1;
        for (int k = 1; k <= 4000 && done_k == 0; k++) begin
            tick();
            if (bus.o_tx_valid && first_v == 0) first_v = k;
            if (bus.o_done && done_k == 0) done_k = k;
            if (k == reset_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_tx_valid", 32'(bus.o_tx_valid), 32'd0);
                check("rst_busy", 32'(bus.o_busy), 32'd0);
                check("rst_read_enable", 32'(bus.o_read_enable), 32'd0);
                check("rst_read_addr", 32'(bus.o_read_addr), 32'd0);
                check("bytes_before_reset", 32'(bytes_seen), 32'd21);
                exp_q.delete();
                bus.i_start = 1'b0;
                tick();
                tick();
                rst_n = 1'b1;
                tick();
                return;
            end
            if (stall_at != 0 && k == stall_at + 500) begin
                check("stall_busy", 32'(bus.o_busy), 32'd1);
                check("stall_valid", 32'(bus.o_tx_valid), 32'd1);
                check("stall_data", 32'(bus.o_tx_data), 32'h03);
                check("stall_bytes", 32'(bytes_seen), 32'd12);
            end
            bus.i_start = (k == restart_at) ? 1'b1 : 1'b0;
            if (rand_rdy) begin
                bus.i_tx_ready = 1'($urandom_range(0, 1));
            end else if (stall_at != 0 && k >= stall_at && k < stall_at + 1000) begin
                bus.i_tx_ready = 1'b0;
            end else begin
                bus.i_tx_ready = 1'b1;
            end
        end
        bus.i_start    = 1'b0;
        bus.i_tx_ready = 1'b1;
        if (done_k == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: got no o_done, expected one within 4000 cycles");
        end
        if (exp_done != 0) begin
            check("first_valid_latency", 32'(first_v), 32'd3);
            check("done_latency", 32'(done_k), 32'(exp_done));
        end
        check("bytes_per_dump", 32'(bytes_seen), 32'd128);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("read_enable_cycles", 32'(re_cnt), 32'd32);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("done_after", 32'(bus.o_done), 32'd0);
            check("idle_busy", 32'(bus.o_busy), 32'd0);
        end
        check("done_pulses", 32'(done_cnt), 32'd1);
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.i_start     = 1'b0;
        bus.i_tx_ready  = 1'b0;
        bus.i_read_data = 32'h0;
        for (int r = 0; r < 32; r++) begin
            bank[r] = 32'hA500_0000 | 32'(r);
        end
        tick();
        tick();
        check("reset_read_enable", 32'(bus.o_read_enable), 32'd0);
        check("reset_read_addr", 32'(bus.o_read_addr), 32'd0);
        check("reset_tx_valid", 32'(bus.o_tx_valid), 32'd0);
        check("reset_tx_data", 32'(bus.o_tx_data), 32'd0);
        check("reset_busy", 32'(bus.o_busy), 32'd0);
        check("reset_done", 32'(bus.o_done), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_busy_no_start", 32'(bus.o_busy), 32'd0);

        run_dump(1'b0, 0, 0, 0, 193);   // ready held high
        run_dump(1'b1, 0, 0, 0, 0);     // random ready
        run_dump(1'b0, 50, 0, 0, 193);  // start re-pulsed mid dump
        run_dump(1'b0, 0, 0, 34, 0);    // reset during register 5
        run_dump(1'b0, 0, 0, 0, 193);   // fresh dump after reset
        run_dump(1'b0, 0, 20, 0, 1192); // 1000-cycle ready-low window

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
